bcd_countdown_timer: RTL
========================

// Module: bcd_countdown_timer
//
// PURPOSE
//   Two-digit BCD down-counter. Complements the existing 00->59 up-counter.
//   Software or a front-panel FSM loads a preset time (tens:units) and starts the run.
//   The block decrements once per prescaled tick and stops at 00, raising done.
//   Its units/tens outputs feed the same display path as the up-counter.
//
// PARAMETERS
//   TICK_DIV   1   clock cycles per decrement while running (>=1); prescaler width = $clog2(TICK_DIV)+1
//   MAX_TENS   5   largest legal tens digit; loaded tens above this are clamped to it
//
// PORTS
//   clk            in   1  rising-edge clock
//   reset          in   1  asynchronous, active-high reset
//   load           in   1  sync: capture preset_tens/preset_units (priority over start)
//   preset_tens    in   4  BCD tens digit to load
//   preset_units   in   4  BCD units digit to load
//   start          in   1  level: 1 = run/resume, 0 = pause
//   tens           out  4  current BCD tens digit
//   units          out  4  current BCD units digit
//   busy           out  1  1 while state == RUN
//   done           out  1  1 while state == DONE (count reached 00)
//
// BEHAVIOUR
//   Reset (async, any time, incl. mid-run)
//     - tens=0, units=0, busy=0, done=0, prescaler=0, state=IDLE, effective immediately.
//   States
//     - IDLE, RUN, PAUSE, DONE. busy and done are decoded from state (registered, no comb paths from inputs).
//   load=1 (any state, checked first)
//     - tens <= min(preset_tens, MAX_TENS).
//     - units <= min(preset_units, 9).
//     - prescaler <= 0, state <= IDLE. start is ignored that cycle.
//   IDLE
//     - start=1 and value!=00 -> RUN.
//     - start=1 and value==00 -> DONE (no decrement, never underflows).
//   RUN
//     - If start=0: go to PAUSE; prescaler is held.
//     - Else: prescaler counts 0..TICK_DIV-1 and wraps; tick = (prescaler==TICK_DIV-1).
//   Tick (decrement)
//     - units!=0: units-1.
//     - units==0: units<=9, tens-1.
//     - If the decrement yields 00: state <= DONE on the same edge, so done rises with value 00.
//   Latency
//     - First decrement TICK_DIV cycles after the edge that entered RUN from IDLE.
//     - With TICK_DIV=1: one decrement per RUN cycle; preset NN reaches 00 after exactly NN(decimal) RUN cycles.
//   PAUSE
//     - Value and prescaler frozen, busy=0.
//     - start=1 -> RUN, resuming the prescaler phase (no lost or extra tick).
//   DONE
//     - Value held at 00, done=1. start ignored; exit only via load or reset.
//   Invariants
//     - units<=9 and tens<=MAX_TENS at all times.
//     - tens:units never wraps from 00 to 99.
//
// TESTING
//   1 TICK_DIV=1, load 5,9, start=1 held -> 59,58..50,49..00.
//     done=1 on the edge showing 00 (59 RUN cycles); held 00 afterwards.
//   2 load 1,0, start -> after 1 tick tens=0 units=9 (units borrow wrap); next tick 08.
//   3 TICK_DIV=4, load 0,5, start; drop start after 6 RUN cycles for 5 cycles
//     -> value frozen at 04, busy=0; resume -> next decrement after 2 more RUN cycles.
//   4 load 0,0, start=1 -> DONE next edge, done=1, value stays 00 (no 99).
//   5 Load clamping -> load C,C gives tens=5 units=9.
//   6 Load priority -> load 3,0 with start=1 during RUN gives IDLE, value 30, busy=0 that cycle.
//   7 Reset mid-run -> assert reset between clock edges at value 37
//     -> outputs 00 and busy/done=0 before the next edge; deassert -> IDLE.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD down-counter: loads a preset tens:units value, decrements once per
// prescaled tick while running, and parks at 00 with done raised.
module bcd_countdown_timer #(
  parameter int TICK_DIV = 1,
  parameter int MAX_TENS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_units,
  input  logic       start,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
);

  localparam int              PW         = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [3:0]      TENS_MAX   = 4'(MAX_TENS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [3:0]    r_tens;
  logic [3:0]    r_units;
  logic [PW-1:0] r_presc;

  logic [3:0] w_load_tens;
  logic [3:0] w_load_units;
  logic       w_zero;
  logic       w_last;

  assign w_load_tens  = (preset_tens  > TENS_MAX) ? TENS_MAX : preset_tens;
  assign w_load_units = (preset_units > 4'd9)     ? 4'd9     : preset_units;
  assign w_zero       = (r_tens == 4'd0) && (r_units == 4'd0);
  // Value 01 is the only one whose decrement lands on 00.
  assign w_last       = (r_tens == 4'd0) && (r_units == 4'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_tens  <= 4'd0;
      r_units <= 4'd0;
      r_presc <= '0;
    end else if (load) begin
      r_state <= S_IDLE;
      r_tens  <= w_load_tens;
      r_units <= w_load_units;
      r_presc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= w_zero ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (!start) begin
            r_state <= S_PAUSE;
          end else if (r_presc == PRESC_LAST) begin
            r_presc <= '0;
            if (r_units != 4'd0) begin
              r_units <= r_units - 4'd1;
            end else begin
              r_units <= 4'd9;
              r_tens  <= r_tens - 4'd1;
            end
            if (w_last) r_state <= S_DONE;
          end else begin
            r_presc <= r_presc + PRESC_ONE;
          end
        end
        S_PAUSE: begin
          if (start) r_state <= S_RUN;
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tens      = r_tens;
  assign units     = r_units;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule
